vx_sfu_pe_ordered_switch: RTL and testbench

- Parametrised request/response switch between one SFU dispatch stream and PE_COUNT processing elements (wctl, csr, and future SFU PEs).
- Routes each request to the PE chosen by req_pe_sel and tracks issue order in a tag FIFO.
- Returns results strictly in issue order, even when PEs have different latencies.
- Adds per-PE outstanding-request limits and a registered response stage.

---
 rtl/vx_sfu_pe_ordered_switch.sv | 151 +++++++++++++++
 tb/tb_vx_sfu_pe_ordered_switch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_sfu_pe_ordered_switch.sv
// Ordered request/response switch between the SFU dispatch stream and its PEs.
// Responses are returned strictly in issue order using a tag FIFO of PE indices.
module vx_sfu_pe_ordered_switch #(
   parameter int PE_COUNT    = 2,
   parameter int DATA_WIDTH  = 64,
   parameter int RSP_WIDTH   = 64,
   parameter int ORDER_DEPTH = 8,
   parameter int MAX_PENDING = 4,
   parameter int PE_SEL_BITS = $clog2(PE_COUNT)
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      req_valid,
   input  logic [DATA_WIDTH-1:0]                     req_data,
   input  logic [PE_SEL_BITS-1:0]                    req_pe_sel,
   output logic                                      req_ready,
   output logic [PE_COUNT-1:0]                       pe_req_valid,
   output logic [PE_COUNT*DATA_WIDTH-1:0]            pe_req_data,
   input  logic [PE_COUNT-1:0]                       pe_req_ready,
   input  logic [PE_COUNT-1:0]                       pe_rsp_valid,
   input  logic [PE_COUNT*RSP_WIDTH-1:0]             pe_rsp_data,
   output logic [PE_COUNT-1:0]                       pe_rsp_ready,
   output logic                                      rsp_valid,
   output logic [RSP_WIDTH-1:0]                      rsp_data,
   output logic [PE_SEL_BITS-1:0]                    rsp_pe,
   input  logic                                      rsp_ready,
   output logic [PE_COUNT*$clog2(MAX_PENDING+1)-1:0] pending_cnt,
   output logic                                      idle
);

   localparam int CW = $clog2(MAX_PENDING + 1);
   localparam int AW = $clog2(ORDER_DEPTH);

   logic [PE_SEL_BITS-1:0] r_ord [ORDER_DEPTH];
   logic [AW-1:0]          r_wr;
   logic [AW-1:0]          r_rd;
   logic [AW:0]            r_cnt;
   logic [CW-1:0]          r_pend [PE_COUNT];
   logic                   r_rsp_valid;
   logic [RSP_WIDTH-1:0]   r_rsp_data;
   logic [PE_SEL_BITS-1:0] r_rsp_pe;

   logic                   w_full;
   logic                   w_empty;
   logic                   w_sel_ok;
   logic                   w_out_en;
   logic                   w_issue;
   logic                   w_take;
   logic [PE_SEL_BITS-1:0] w_head;
   logic [RSP_WIDTH-1:0]   w_head_data;
   logic [PE_COUNT-1:0]    w_req_v;
   logic [PE_COUNT-1:0]    w_rsp_r;
   logic [PE_COUNT-1:0]    w_inc;
   logic [PE_COUNT-1:0]    w_dec;

   assign w_full   = (r_cnt == (AW+1)'(ORDER_DEPTH));
   assign w_empty  = (r_cnt == '0);
   assign w_sel_ok = ({1'b0, req_pe_sel} < (PE_SEL_BITS+1)'(PE_COUNT));
   assign w_head   = r_ord[r_rd];
   assign w_out_en = !r_rsp_valid || rsp_ready;

   // Request steering, head-of-order response gating and per-PE count deltas
   always_comb begin
      w_req_v     = '0;
      w_rsp_r     = '0;
      w_inc       = '0;
      w_dec       = '0;
      w_head_data = '0;
      pe_req_data = '0;
      pending_cnt = '0;
      for (int i = 0; i < PE_COUNT; i++) begin
         pe_req_data[i*DATA_WIDTH +: DATA_WIDTH] = req_data;
         pending_cnt[i*CW +: CW] = r_pend[i];
         w_req_v[i] = req_valid && w_sel_ok && !w_full &&
                      (req_pe_sel == PE_SEL_BITS'(i)) &&
                      (r_pend[i] < CW'(MAX_PENDING));
         w_rsp_r[i] = !w_empty && w_out_en &&
                      (w_head == PE_SEL_BITS'(i));
         w_inc[i] = w_req_v[i] && pe_req_ready[i];
         w_dec[i] = w_rsp_r[i] && pe_rsp_valid[i];
         if (w_head == PE_SEL_BITS'(i))
            w_head_data = pe_rsp_data[i*RSP_WIDTH +: RSP_WIDTH];
      end
   end

   assign w_issue      = |w_inc;
   assign w_take       = |w_dec;
   assign req_ready    = w_issue;
   assign pe_req_valid = w_req_v;
   assign pe_rsp_ready = w_rsp_r;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_data     = r_rsp_data;
   assign rsp_pe       = r_rsp_pe;
   assign idle         = w_empty && !r_rsp_valid;

   // Order FIFO storage: record target PE of every issued request
   always_ff @(posedge clk) begin
      if (w_issue)
         r_ord[r_wr] <= req_pe_sel;
   end

   // Order FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_issue)
            r_wr <= r_wr + 1'b1;
         if (w_take)
            r_rd <= r_rd + 1'b1;
         case ({w_issue, w_take})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Per-PE outstanding counters; issue and retire together cancel
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PE_COUNT; i++)
            r_pend[i] <= '0;
      end else begin
         for (int i = 0; i < PE_COUNT; i++) begin
            if (w_inc[i] && !w_dec[i])
               r_pend[i] <= r_pend[i] + 1'b1;
            else if (!w_inc[i] && w_dec[i])
               r_pend[i] <= r_pend[i] - 1'b1;
         end
      end
   end

   // Registered response stage; holds data while downstream stalls
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_pe    <= '0;
      end else if (w_take) begin
         r_rsp_valid <= 1'b1;
         r_rsp_data  <= w_head_data;
         r_rsp_pe    <= w_head;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vx_sfu_pe_ordered_switch.sv
// Directed bench for vx_sfu_pe_ordered_switch (3 PEs, depth 8, limit 4).
// Inputs change 1ns after posedge; outputs are checked before the next edge.
module tb_vx_sfu_pe_ordered_switch;

   localparam int PEC = 3;
   localparam int DW  = 16;
   localparam int RW  = 16;
   localparam int OD  = 8;
   localparam int MP  = 4;
   localparam int SB  = 2;
   localparam int CW  = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              req_valid = 1'b0;
   logic [DW-1:0]     req_data = '0;
   logic [SB-1:0]     req_pe_sel = '0;
   logic              req_ready;
   logic [PEC-1:0]    pe_req_valid;
   logic [PEC*DW-1:0] pe_req_data;
   logic [PEC-1:0]    pe_req_ready = '1;
   logic [PEC-1:0]    pe_rsp_valid = '0;
   logic [PEC*RW-1:0] pe_rsp_data = '0;
   logic [PEC-1:0]    pe_rsp_ready;
   logic              rsp_valid;
   logic [RW-1:0]     rsp_data;
   logic [SB-1:0]     rsp_pe;
   logic              rsp_ready = 1'b1;
   logic [PEC*CW-1:0] pending_cnt;
   logic              idle;

   int checks = 0;
   int errors = 0;

   vx_sfu_pe_ordered_switch #(
      .PE_COUNT(PEC), .DATA_WIDTH(DW), .RSP_WIDTH(RW),
      .ORDER_DEPTH(OD), .MAX_PENDING(MP), .PE_SEL_BITS(SB)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data),
      .req_pe_sel(req_pe_sel), .req_ready(req_ready),
      .pe_req_valid(pe_req_valid), .pe_req_data(pe_req_data),
      .pe_req_ready(pe_req_ready),
      .pe_rsp_valid(pe_rsp_valid), .pe_rsp_data(pe_rsp_data),
      .pe_rsp_ready(pe_rsp_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_pe(rsp_pe),
      .rsp_ready(rsp_ready),
      .pending_cnt(pending_cnt), .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic v, input logic [SB-1:0] s,
                      input logic [DW-1:0] d);
      req_valid  = v;
      req_pe_sel = s;
      req_data   = d;
   endtask

   task automatic prsp(input logic [PEC-1:0] v, input int pe,
                       input logic [RW-1:0] d);
      pe_rsp_valid = v;
      pe_rsp_data[pe*RW +: RW] = d;
   endtask

   initial begin
      // ---- reset state ----
      #2 reset = 1'b0;
      #1;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_rsp_pe", 64'(rsp_pe), 64'd0);
      chk("rst_pending", 64'(pending_cnt), 64'd0);
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      tick();
      @(negedge clk) reset = 1'b1;
      tick();

      // ---- out-of-order latency: A->PE1 slow, B->PE0 fast ----
      req(1'b1, 2'd1, 16'hAAAA);
      #1;
      chk("ooo_req_ready_a", 64'(req_ready), 64'd1);
      chk("ooo_pe_req_valid_a", 64'(pe_req_valid), 64'b010);
      chk("ooo_pe_req_data", 64'(pe_req_data), 64'hAAAA_AAAA_AAAA);
      tick();
      req(1'b1, 2'd0, 16'hBBBB);
      #1;
      chk("ooo_req_ready_b", 64'(req_ready), 64'd1);
      tick();
      req(1'b0, 2'd0, 16'h0);
      chk("ooo_pending", 64'(pending_cnt), 64'h009);
      chk("ooo_idle_busy", 64'(idle), 64'd0);
      prsp(3'b001, 0, 16'hB0B0);
      #1;
      chk("ooo_hold_pe0", 64'(pe_rsp_ready), 64'b010);
      tick();
      chk("ooo_no_rsp_1", 64'(rsp_valid), 64'd0);
      tick();
      chk("ooo_no_rsp_2", 64'(rsp_valid), 64'd0);
      chk("ooo_hold_pe0_2", 64'(pe_rsp_ready), 64'b010);
      prsp(3'b011, 1, 16'hA0A0);
      tick();
      chk("ooo_a_valid", 64'(rsp_valid), 64'd1);
      chk("ooo_a_data", 64'(rsp_data), 64'hA0A0);
      chk("ooo_a_pe", 64'(rsp_pe), 64'd1);
      prsp(3'b001, 1, 16'h0);
      #1;
      chk("ooo_release_pe0", 64'(pe_rsp_ready), 64'b001);
      tick();
      chk("ooo_b_valid", 64'(rsp_valid), 64'd1);
      chk("ooo_b_data", 64'(rsp_data), 64'hB0B0);
      chk("ooo_b_pe", 64'(rsp_pe), 64'd0);
      prsp(3'b000, 0, 16'h0);
      tick();
      chk("ooo_drained", 64'(rsp_valid), 64'd0);
      chk("ooo_idle", 64'(idle), 64'd1);
      chk("ooo_pending_zero", 64'(pending_cnt), 64'd0);

      // ---- per-PE limit: PE0 silent, 5 requests ----
      for (int i = 0; i < 4; i++) begin
         req(1'b1, 2'd0, 16'(16'h1000 + i));
         #1;
         chk("lim_issue", 64'(req_ready), 64'd1);
         tick();
      end
      #1;
      chk("lim_5th_blocked", 64'(req_ready), 64'd0);
      chk("lim_5th_no_valid", 64'(pe_req_valid), 64'd0);
      chk("lim_pending0", 64'(pending_cnt), 64'h004);
      req(1'b1, 2'd1, 16'h2000);
      #1;
      chk("lim_pe1_ok", 64'(req_ready), 64'd1);
      tick();
      chk("lim_pending", 64'(pending_cnt), 64'h00C);

      // ---- order FIFO full: 8 tags outstanding ----
      for (int i = 0; i < 2; i++) begin
         req(1'b1, 2'd1, 16'(16'h2001 + i));
         #1;
         chk("full_fill_pe1", 64'(req_ready), 64'd1);
         tick();
      end
      req(1'b1, 2'd2, 16'h3000);
      #1;
      chk("full_fill_pe2", 64'(req_ready), 64'd1);
      tick();
      req(1'b1, 2'd2, 16'h3001);
      #1;
      chk("full_9th_blocked", 64'(req_ready), 64'd0);
      chk("full_9th_no_valid", 64'(pe_req_valid), 64'd0);
      chk("full_pending", 64'(pending_cnt), 64'h05C);
      prsp(3'b001, 0, 16'hC0C0);
      #1;
      chk("full_pop_ready", 64'(pe_rsp_ready), 64'b001);
      chk("full_pop_push_blk", 64'(req_ready), 64'd0);
      tick();
      prsp(3'b000, 0, 16'h0);
      chk("full_pop_rsp", 64'(rsp_data), 64'hC0C0);
      #1;
      chk("full_next_accept", 64'(req_ready), 64'd1);
      tick();
      req(1'b0, 2'd0, 16'h0);
      chk("full_pending_after", 64'(pending_cnt), 64'h09B);

      // ---- async reset with tags in flight ----
      #1 reset = 1'b0;
      #1;
      chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("arst_pending", 64'(pending_cnt), 64'd0);
      chk("arst_idle", 64'(idle), 64'd1);
      tick();
      @(negedge clk) reset = 1'b1;
      tick();

      // ---- backpressure: 3 responses, rsp_ready toggling ----
      for (int i = 0; i < 3; i++) begin
         req(1'b1, 2'd0, 16'(16'h4000 + i));
         tick();
      end
      req(1'b0, 2'd0, 16'h0);
      chk("bp_pending", 64'(pending_cnt), 64'h003);
      prsp(3'b001, 0, 16'hE000);
      rsp_ready = 1'b1;
      tick();
      chk("bp_r0_valid", 64'(rsp_valid), 64'd1);
      chk("bp_r0_data", 64'(rsp_data), 64'hE000);
      prsp(3'b001, 0, 16'hE001);
      rsp_ready = 1'b0;
      #1;
      chk("bp_stall_gate", 64'(pe_rsp_ready), 64'b000);
      tick();
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold_data", 64'(rsp_data), 64'hE000);
      rsp_ready = 1'b1;
      tick();
      chk("bp_r1_data", 64'(rsp_data), 64'hE001);
      prsp(3'b001, 0, 16'hE002);
      rsp_ready = 1'b0;
      tick();
      chk("bp_hold1_data", 64'(rsp_data), 64'hE001);
      rsp_ready = 1'b1;
      tick();
      chk("bp_r2_data", 64'(rsp_data), 64'hE002);
      chk("bp_r2_pe", 64'(rsp_pe), 64'd0);
      rsp_ready = 1'b0;
      tick();
      chk("bp_hold2_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold2_data", 64'(rsp_data), 64'hE002);
      rsp_ready = 1'b1;
      #1;
      chk("bp_spurious", 64'(pe_rsp_ready), 64'b000);
      tick();
      chk("bp_done_valid", 64'(rsp_valid), 64'd0);
      chk("bp_done_idle", 64'(idle), 64'd1);
      prsp(3'b000, 0, 16'h0);

      // ---- streaming: 6 back-to-back with concurrent issue ----
      for (int i = 0; i < 3; i++) begin
         req(1'b1, 2'd0, 16'(16'h5000 + i));
         tick();
      end
      for (int j = 0; j < 6; j++) begin
         req(1'b1, 2'd0, 16'(16'h5100 + j));
         prsp(3'b001, 0, 16'(16'hD000 + j));
         #1;
         chk("st_issue", 64'(req_ready), 64'd1);
         tick();
         chk("st_valid", 64'(rsp_valid), 64'd1);
         chk("st_data", 64'(rsp_data), 64'(16'hD000 + j));
         chk("st_pending", 64'(pending_cnt), 64'h003);
      end
      req(1'b0, 2'd0, 16'h0);
      for (int j = 0; j < 3; j++) begin
         prsp(3'b001, 0, 16'(16'hD006 + j));
         tick();
         chk("dr_data", 64'(rsp_data), 64'(16'hD006 + j));
      end
      prsp(3'b000, 0, 16'h0);
      tick();
      chk("dr_idle", 64'(idle), 64'd1);

      // ---- same-cycle issue and retire on PE1 ----
      for (int i = 0; i < 2; i++) begin
         req(1'b1, 2'd1, 16'(16'h6000 + i));
         tick();
      end
      chk("sim_pending_pre", 64'(pending_cnt), 64'h010);
      req(1'b1, 2'd1, 16'h6002);
      prsp(3'b010, 1, 16'hF1F1);
      #1;
      chk("sim_issue", 64'(req_ready), 64'd1);
      chk("sim_take", 64'(pe_rsp_ready), 64'b010);
      tick();
      prsp(3'b000, 1, 16'h0);
      chk("sim_pending_post", 64'(pending_cnt), 64'h010);
      chk("sim_rsp_pe", 64'(rsp_pe), 64'd1);

      // ---- illegal select ----
      req(1'b1, 2'd3, 16'h7777);
      #1;
      chk("ill_req_ready", 64'(req_ready), 64'd0);
      chk("ill_pe_req_valid", 64'(pe_req_valid), 64'd0);
      tick();
      chk("ill_pending", 64'(pending_cnt), 64'h010);
      req(1'b0, 2'd0, 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
